// File: rtl/arm_pkg.sv
// rtl/arm_pkg.sv - shared select codes and stage-entry type for the forwarding unit
package arm_pkg;

  localparam int SEL_RF  = 0;
  localparam int SEL_MEM = 1;
  localparam int SEL_WB  = 2;

  // Destination field is sized for the widest register index we support (REG_W <= 8).
  localparam int DST_MAX_W = 8;

  typedef logic [DST_MAX_W-1:0] dst_t;

  typedef struct packed {
    logic vld;
    dst_t dst;
    logic ld;
  } stage_t;

endpackage

// File: rtl/fwd_hazard_tracker_match.sv
// rtl/fwd_hazard_tracker_match.sv - one source operand versus the post-EX stage array
module fwd_match
  import arm_pkg::*;
#(
  parameter int REG_W = 4,
  parameter int DEPTH = 2,
  parameter int SEL_W = 3
) (
  input  logic [REG_W-1:0] src_i,
  input  logic             src_valid_i,
  input  stage_t [DEPTH:1] stages_i,
  output logic [SEL_W-1:0] sel_o,
  output logic             hit_o,
  output logic             load_hit_o
);

  always_comb begin
    sel_o      = SEL_W'(SEL_RF);
    hit_o      = 1'b0;
    load_hit_o = 1'b0;
    // Walk from the farthest stage inward so the nearest match is written last.
    for (int k = DEPTH; k >= 1; k--) begin
      if (src_valid_i && stages_i[k].vld && (stages_i[k].dst == dst_t'(src_i))) begin
        sel_o = SEL_W'(k);
        hit_o = 1'b1;
      end
    end
    if (src_valid_i && stages_i[1].vld && stages_i[1].ld &&
        (stages_i[1].dst == dst_t'(src_i))) begin
      load_hit_o = 1'b1;
    end
  end

endmodule

// File: rtl/fwd_hazard_tracker.sv
// rtl/fwd_hazard_tracker.sv - post-EX write tracker with forwarding selects, load-use stall and stall counter
module fwd_hazard_tracker
  import arm_pkg::*;
#(
  parameter int REG_W = 4,
  parameter int NSRC  = 3,
  parameter int DEPTH = 2,
  parameter int SEL_W = 3,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  forwardEnIn,
  input  logic                  advanceIn,
  input  logic                  flushIn,
  input  logic                  exWbEnIn,
  input  logic [REG_W-1:0]      exDestIn,
  input  logic                  exMemReadIn,
  input  logic [NSRC*REG_W-1:0] srcIn,
  input  logic [NSRC-1:0]       srcValidIn,
  output logic [NSRC*SEL_W-1:0] selSrcOut,
  output logic                  stallOut,
  output logic [CNT_W-1:0]      stallCountOut
);

  stage_t [DEPTH:1]      stage_q, stage_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [NSRC-1:0]       hit, load_hit;
  logic [NSRC*SEL_W-1:0] sel_raw;

  for (genvar i = 0; i < NSRC; i++) begin : g_match
    fwd_match #(
      .REG_W (REG_W),
      .DEPTH (DEPTH),
      .SEL_W (SEL_W)
    ) u_match (
      .src_i       (srcIn[i*REG_W +: REG_W]),
      .src_valid_i (srcValidIn[i]),
      .stages_i    (stage_q),
      .sel_o       (sel_raw[i*SEL_W +: SEL_W]),
      .hit_o       (hit[i]),
      .load_hit_o  (load_hit[i])
    );
  end

  // Without forwarding any in-flight producer must drain before the consumer proceeds.
  assign stallOut      = forwardEnIn ? |load_hit : |hit;
  assign selSrcOut     = forwardEnIn ? sel_raw : '0;
  assign stallCountOut = cnt_q;

  always_comb begin
    stage_d = stage_q;
    if (advanceIn) begin
      stage_d[1].vld = exWbEnIn & ~flushIn;
      stage_d[1].dst = dst_t'(exDestIn);
      stage_d[1].ld  = exMemReadIn & ~flushIn;
      for (int k = 2; k <= DEPTH; k++) begin
        stage_d[k] = stage_q[k-1];
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (stallOut && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      stage_q <= '0;
      cnt_q   <= '0;
    end else begin
      stage_q <= stage_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_fwd_hazard_tracker.sv
// tb/tb_fwd_hazard_tracker.sv - vector table and scoreboard bench for fwd_hazard_tracker
module tb_fwd_hazard_tracker;

  typedef struct {
    string       name;
    logic        fwd;
    logic        adv;
    logic        flush;
    logic        wb;
    logic        ld;
    logic [3:0]  dest;
    logic [11:0] src;
    logic [2:0]  srcv;
    logic [8:0]  sel;
    logic        stall;
    logic [15:0] cnt;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        fwd_en, adv, flush, wb_en, mem_rd;
  logic [3:0]  dest;
  logic [11:0] src;
  logic [2:0]  src_v;
  logic [8:0]  sel, sel_sat;
  logic        stall, stall_sat;
  logic [15:0] cnt;
  logic [3:0]  cnt_sat;

  int n_checks = 0;
  int n_fail   = 0;
  vec_t tbl[$];
  vec_t exp_q[$];

  always #5 clk = ~clk;

  fwd_hazard_tracker dut (
    .clk(clk), .rst(rst), .forwardEnIn(fwd_en), .advanceIn(adv), .flushIn(flush),
    .exWbEnIn(wb_en), .exDestIn(dest), .exMemReadIn(mem_rd), .srcIn(src),
    .srcValidIn(src_v), .selSrcOut(sel), .stallOut(stall), .stallCountOut(cnt)
  );

  fwd_hazard_tracker #(.CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .forwardEnIn(fwd_en), .advanceIn(adv), .flushIn(flush),
    .exWbEnIn(wb_en), .exDestIn(dest), .exMemReadIn(mem_rd), .srcIn(src),
    .srcValidIn(src_v), .selSrcOut(sel_sat), .stallOut(stall_sat), .stallCountOut(cnt_sat)
  );

  function automatic vec_t mk(string n, logic f, logic a, logic fl, logic w, logic l,
                              logic [3:0] d, logic [11:0] s, logic [2:0] sv,
                              logic [8:0] es, logic est, logic [15:0] ec);
    vec_t v;
    v.name = n; v.fwd = f; v.adv = a; v.flush = fl; v.wb = w; v.ld = l;
    v.dest = d; v.src = s; v.srcv = sv; v.sel = es; v.stall = est; v.cnt = ec;
    return v;
  endfunction

  task automatic check_bits(string n, logic [15:0] act, logic [15:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", n, act, req);
    end
  endtask

  // Drive on the falling edge, record the expectation, then compare mid-low-phase.
  task automatic apply(vec_t v);
    vec_t e;
    logic [15:0] sat_exp;
    @(negedge clk);
    fwd_en = v.fwd; adv = v.adv; flush = v.flush; wb_en = v.wb; mem_rd = v.ld;
    dest = v.dest; src = v.src; src_v = v.srcv;
    exp_q.push_back(v);
    #2;
    if (exp_q.size() == 0) begin
      n_checks++; n_fail++;
      $display("FAIL %s: scoreboard empty", v.name);
    end else begin
      e = exp_q.pop_front();
      sat_exp = (e.cnt > 16'd15) ? 16'd15 : e.cnt;
      check_bits({e.name, ".sel"}, {7'd0, sel}, {7'd0, e.sel});
      check_bits({e.name, ".stall"}, {15'd0, stall}, {15'd0, e.stall});
      check_bits({e.name, ".cnt"}, cnt, e.cnt);
      check_bits({e.name, ".cnt_sat"}, {12'd0, cnt_sat}, sat_exp);
    end
  endtask

  initial begin
    rst = 1'b0; fwd_en = 1'b1; adv = 1'b0; flush = 1'b0; wb_en = 1'b0; mem_rd = 1'b0;
    dest = '0; src = '0; src_v = '0;

    tbl.push_back(mk("reset_idle", 1,0,0,0,0,4'd0,12'h000,3'b000,9'o000,0,16'd0));
    tbl.push_back(mk("pri_push1",  1,1,0,1,0,4'd3,12'h003,3'b001,9'o000,0,16'd0));
    tbl.push_back(mk("pri_push2",  1,1,0,1,0,4'd3,12'h003,3'b001,9'o001,0,16'd0));
    tbl.push_back(mk("pri_near",   1,1,0,1,0,4'd9,12'h003,3'b001,9'o001,0,16'd0));
    tbl.push_back(mk("pri_wb",     1,0,0,0,0,4'd0,12'h003,3'b001,9'o002,0,16'd0));
    tbl.push_back(mk("ld_push",    1,1,0,1,1,4'd5,12'h050,3'b010,9'o000,0,16'd0));
    tbl.push_back(mk("ld_stall",   1,1,1,1,1,4'd5,12'h050,3'b010,9'o010,1,16'd0));
    tbl.push_back(mk("ld_fwd_wb",  1,0,0,0,0,4'd0,12'h050,3'b010,9'o020,0,16'd1));
    tbl.push_back(mk("r7_push",    1,1,0,1,0,4'd7,12'h000,3'b000,9'o000,0,16'd1));
    tbl.push_back(mk("r7_age",     1,1,0,0,0,4'd0,12'h000,3'b000,9'o000,0,16'd1));
    tbl.push_back(mk("so_stall",   0,0,0,0,0,4'd0,12'h700,3'b100,9'o000,1,16'd1));
    tbl.push_back(mk("so_novalid", 0,0,0,0,0,4'd0,12'h700,3'b000,9'o000,0,16'd2));
    tbl.push_back(mk("fwd_r7_wb",  1,0,0,0,0,4'd0,12'h700,3'b100,9'o200,0,16'd2));
    tbl.push_back(mk("flush_r2",   1,1,1,1,0,4'd2,12'h000,3'b000,9'o000,0,16'd2));
    tbl.push_back(mk("r2_nomatch", 1,1,0,1,0,4'd4,12'h002,3'b001,9'o000,0,16'd2));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk("hold_r4",  1,0,1,1,0,4'd6,12'h004,3'b001,9'o001,0,16'd2));
    tbl.push_back(mk("all_r4",     1,0,0,0,0,4'd0,12'h444,3'b111,9'o111,0,16'd2));
    tbl.push_back(mk("sat_push",   1,1,0,1,1,4'd8,12'h000,3'b000,9'o000,0,16'd2));
    for (int i = 0; i < 20; i++)
      tbl.push_back(mk("sat_stall", 1,0,0,0,0,4'd0,12'h008,3'b001,9'o001,1,16'(2 + i)));
    tbl.push_back(mk("sat_end",    1,0,0,0,0,4'd0,12'h008,3'b000,9'o000,0,16'd22));

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

    // Reset must win over a same-cycle advance of a valid write.
    @(negedge clk);
    rst = 1'b0; adv = 1'b1; wb_en = 1'b1; dest = 4'd4; mem_rd = 1'b0; flush = 1'b0; src_v = '0;
    @(negedge clk);
    rst = 1'b1; adv = 1'b0; wb_en = 1'b0;
    apply(mk("rst_override", 1,0,0,0,0,4'd0,12'h004,3'b001,9'o000,0,16'd0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
